// File: rtl/bin_to_bcd8_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Saturation is selected with the BIN_TO_BCD8_SAT_EN macro in bin_to_bcd8.sv.
package bin_to_bcd8_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    localparam int          BCD_DIGITS  = 8;
    localparam logic [26:0] BCD_MAX_DEC = 27'd99_999_999;
    localparam logic [31:0] BCD_SAT     = 32'h9999_9999;

endpackage

// File: rtl/bin_to_bcd8_if.sv
// Request/result bus between a producer and the binary-to-BCD converter.
// The result side wires straight to the display driver's data/disp_en.
interface bin_to_bcd8_if #(
    parameter int BIN_W = 27
);

    logic             start;
    logic [BIN_W-1:0] bin;
    logic [31:0]      bcd;
    logic             disp_en;
    logic             busy;
    logic             done;
    logic             overflow;

    modport master (
        output start, bin,
        input  bcd, disp_en, busy, done, overflow
    );

    modport slave (
        input  start, bin,
        output bcd, disp_en, busy, done, overflow
    );

endinterface

// File: rtl/bin_to_bcd8_digit_adj.sv
// Double-dabble nibble corrector: values 5..15 get +3, no carry out.
// Instantiated once per scratch digit by bin_to_bcd8.
module bcd_digit_adj (
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin_to_bcd8.sv
// Iterative shift-and-add-3 binary to 8-digit BCD converter, double-buffered.
// Define BIN_TO_BCD8_SAT_EN to clamp overflowing inputs to 9999_9999.
module bin_to_bcd8 #(
    parameter int BIN_W = 27
) (
    input  logic   clk,
    input  logic   reset_n,
    bin_to_bcd8_if.slave bus
);

    import bin_to_bcd8_pkg::*;

    localparam int            CW       = $clog2(BIN_W);
    localparam logic [CW-1:0] CNT_INIT = CW'(BIN_W - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [BIN_W-1:0] shift_q;
    logic [31:0]      scratch_q;
    logic [31:0]      scratch_adj;
    logic [31:0]      scratch_nxt;
    logic [31:0]      bcd_q;
    logic [31:0]      bcd_load;
    logic             disp_en_q;
    logic             done_q;
    logic             ovf_q;
    logic             accept;
    logic             last;

    for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (scratch_q[4*i +: 4]),
            .q (scratch_adj[4*i +: 4])
        );
    end

    // Bit 31 of the adjusted scratch falls off: result is bin mod 10^8.
    assign scratch_nxt = {scratch_adj[30:0], shift_q[BIN_W-1]};

`ifdef BIN_TO_BCD8_SAT_EN
    assign bcd_load = ovf_q ? BCD_SAT : scratch_nxt;
`else
    assign bcd_load = scratch_nxt;
`endif

    assign accept = (state_q == IDLE) && bus.start;
    assign last   = (state_q == CONV) && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = CONV;
            CONV:    if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Output bank loads on the final shift so it is visible in DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            shift_q   <= '0;
            scratch_q <= '0;
            bcd_q     <= '0;
            disp_en_q <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            done_q <= last;
            if (accept) begin
                shift_q   <= bus.bin;
                scratch_q <= '0;
                cnt_q     <= CNT_INIT;
                ovf_q     <= 27'(bus.bin) > BCD_MAX_DEC;
            end else if (state_q == CONV) begin
                scratch_q <= scratch_nxt;
                shift_q   <= shift_q << 1;
                cnt_q     <= cnt_q - CW'(1);
            end
            if (last) begin
                bcd_q     <= bcd_load;
                disp_en_q <= 1'b1;
            end
        end
    end

    assign bus.bcd      = bcd_q;
    assign bus.disp_en  = disp_en_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.overflow = ovf_q;

endmodule
